// File: rtl/mod_updown_counter.sv
// Modulo up/down counter with sync clear, parallel load, terminal-count pulse and saturating
// wrap counter; includes a reset synchroniser whose output is exported for neighbouring logic.
module mod_updown_counter #(
    parameter int WIDTH       = 8,
    parameter int MOD_VALUE   = 10,
    parameter int RESET_VALUE = 0,
    parameter int SYNC_STAGES = 2,
    parameter int WRAP_W      = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              rst_sync_n,
    input  logic              sync_clr,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    input  logic              en,
    input  logic              up_dn,
    output logic [WIDTH-1:0]  count,
    output logic              tc,
    output logic [WRAP_W-1:0] wrap_cnt
);

    localparam logic [WIDTH-1:0]  CNT_MAX = WIDTH'(MOD_VALUE - 1);
    localparam logic [WIDTH-1:0]  CNT_RST = WIDTH'(RESET_VALUE);
    localparam logic [WIDTH:0]    MOD_EXT = (WIDTH + 1)'(MOD_VALUE);
    localparam logic [WRAP_W-1:0] WRAP_SAT = '1;

    // Elaboration-time parameter legality checks
    if (WIDTH < 1 || WIDTH > 31) begin : g_chk_width
        $fatal(1, "mod_updown_counter: WIDTH must be 1..31");
    end
    if (MOD_VALUE < 2 || longint'(MOD_VALUE) > (longint'(1) << WIDTH)) begin : g_chk_mod
        $fatal(1, "mod_updown_counter: MOD_VALUE must be 2..2**WIDTH");
    end
    if (RESET_VALUE < 0 || RESET_VALUE >= MOD_VALUE) begin : g_chk_rst
        $fatal(1, "mod_updown_counter: RESET_VALUE must be < MOD_VALUE");
    end
    if (SYNC_STAGES < 2) begin : g_chk_sync
        $fatal(1, "mod_updown_counter: SYNC_STAGES must be >= 2");
    end
    if (WRAP_W < 1) begin : g_chk_wrap
        $fatal(1, "mod_updown_counter: WRAP_W must be >= 1");
    end

    logic [SYNC_STAGES-1:0] r_sync;
    logic [WIDTH-1:0]       r_count;
    logic                   r_tc;
    logic [WRAP_W-1:0]      r_wrap;

    logic [WIDTH-1:0]       w_count_nxt;
    logic                   w_tc_nxt;
    logic [WRAP_W-1:0]      w_wrap_nxt;
    logic [WRAP_W-1:0]      w_wrap_inc;
    logic                   w_load_ok;

    // Reset synchroniser: asynchronous assert, ones shifted in after rst_n release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rst_sync_n = r_sync[SYNC_STAGES-1];

    assign w_load_ok  = ({1'b0, load_val} < MOD_EXT);
    assign w_wrap_inc = (r_wrap == WRAP_SAT) ? r_wrap : r_wrap + WRAP_W'(1);

    // Next-state: sync_clr > load > en; equality against CNT_MAX also covers natural overflow
    always_comb begin
        w_count_nxt = r_count;
        w_tc_nxt    = 1'b0;
        w_wrap_nxt  = r_wrap;
        if (sync_clr) begin
            w_count_nxt = CNT_RST;
            w_wrap_nxt  = '0;
        end else if (load) begin
            w_count_nxt = w_load_ok ? load_val : CNT_MAX;
        end else if (en) begin
            if (up_dn) begin
                if (r_count == CNT_MAX) begin
                    w_count_nxt = '0;
                    w_tc_nxt    = 1'b1;
                    w_wrap_nxt  = w_wrap_inc;
                end else begin
                    w_count_nxt = r_count + WIDTH'(1);
                end
            end else begin
                if (r_count == '0) begin
                    w_count_nxt = CNT_MAX;
                    w_tc_nxt    = 1'b1;
                    w_wrap_nxt  = w_wrap_inc;
                end else begin
                    w_count_nxt = r_count - WIDTH'(1);
                end
            end
        end
    end

    // Datapath held in reset until the synchronised reset releases
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            r_count <= CNT_RST;
            r_tc    <= 1'b0;
            r_wrap  <= '0;
        end else begin
            r_count <= w_count_nxt;
            r_tc    <= w_tc_nxt;
            r_wrap  <= w_wrap_nxt;
        end
    end

    assign count    = r_count;
    assign tc       = r_tc;
    assign wrap_cnt = r_wrap;

endmodule
